uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter DATA_SIZE, default 8, frame data width in bits.
REQ-002 Parameter GAP_WIDTH, default 8, width of the inter-frame gap count.
REQ-003 i_clk  in  1  single clock; all state changes on the rising edge.
REQ-004 i_reset  in  1  reset, asynchronous, active-high.
REQ-005 i_enable  in  1  transmit enable from the APB control register.
REQ-006 i_gap_cycles  in  GAP_WIDTH  idle cycles inserted between frames; 0 means back-to-back frames.
REQ-007 i_fifo_empty  in  1  TX FIFO empty flag.
REQ-008 i_fifo_data  in  DATA_SIZE  TX FIFO head word, show-ahead, valid while not empty.
REQ-009 o_fifo_read_en  out  1  one-cycle pop strobe to the TX FIFO.
REQ-010 i_tx_busy  in  1  serializer busy.
REQ-011 i_tx_done  in  1  serializer one-cycle pulse at end of stop bit.
REQ-012 o_tx_start  out  1  one-cycle frame start strobe to the serializer.
REQ-013 o_tx_data  out  DATA_SIZE  registered byte presented to the serializer.
REQ-014 o_active  out  1  high whenever the FSM is not in IDLE.
REQ-015 o_irq_done  out  1  one-cycle pulse when the FIFO has drained and the last frame has finished.
REQ-016 o_sent_count  out  16  count of completed frames, wraps modulo 2^16.

Function
REQ-017 FSM states: IDLE, POP, START, WAIT_DONE, GAP.
REQ-018 IDLE: i_enable=1 and i_fifo_empty=0 -> POP; otherwise stay in IDLE.
REQ-019 POP lasts exactly 1 cycle.
- o_fifo_read_en=1 in POP.
- o_tx_data captures i_fifo_data on the POP edge.
- Next state is START.
REQ-020 START:
- o_tx_start = (state==START) & ~i_tx_busy.
- Next state is WAIT_DONE on the cycle o_tx_start=1; otherwise stay in START.
- i_enable is ignored, so a popped byte is always sent.
REQ-021 WAIT_DONE: on i_tx_done=1, o_sent_count increments by 1.
- If i_gap_cycles=0, go directly to the decision point (REQ-023).
- Otherwise load the gap counter with i_gap_cycles-1 and go to GAP.
REQ-022 GAP: the counter decrements each cycle; at 0 it goes to the decision point.
- GAP length is exactly i_gap_cycles cycles.
- i_gap_cycles is sampled only on the load.
REQ-023 Decision point:
- i_enable=1 and i_fifo_empty=0 -> POP.
- i_fifo_empty=1 -> IDLE, and o_irq_done=1 on the following cycle.
- i_enable=0 with the FIFO not empty -> IDLE, with no IRQ.
REQ-024 Latency: IDLE with request condition true at edge N -> o_fifo_read_en high in cycle N+1 -> o_tx_start high in cycle N+2 if i_tx_busy=0.
REQ-025 Back-to-back timing with gap 0: the next o_fifo_read_en is high in the cycle after the i_tx_done cycle.
REQ-026 i_tx_done outside WAIT_DONE is ignored and does not change the count.
REQ-027 i_enable deasserted during WAIT_DONE or GAP: the current frame and gap complete, then the FSM goes to IDLE.
REQ-028 o_fifo_read_en is never asserted while i_fifo_empty=1; no underflow pops.
REQ-029 o_sent_count wraps from 16'hFFFF to 0 with no flag.

Reset
REQ-030 Asserting i_reset in any state forces the following immediately:
- FSM to IDLE.
- o_tx_data=0, o_sent_count=0, gap counter=0.
- o_fifo_read_en=0, o_tx_start=0, o_irq_done=0, o_active=0.
REQ-031 Reset in mid-operation drops any popped-but-unsent byte; no recovery is required.
REQ-032 The first request may be accepted on the first rising edge after i_reset deasserts.

Structure
REQ-033 The uart_pkg package holds:
- the sched_state_e enum typedef;
- the default DATA_SIZE and GAP_WIDTH constants.
REQ-034 The block is a single flat module with no sub-module; the gap counter is inline.
REQ-035 Only o_tx_start is Mealy (on i_tx_busy); all other outputs are decoded from registers.

Verification
REQ-036 FIFO holds 0x55, enable=1, gap=0, busy=0.
- Read strobe at N+1, start at N+2, o_tx_data=0x55.
- After done: sent_count=1, o_irq_done pulses one cycle, o_active=0.
REQ-037 FIFO holds 3 bytes (0x11, 0x22, 0x33), gap=4.
- Exactly 3 pops and 3 starts, in that data order.
- Exactly 4 idle cycles between each done and the next pop; one IRQ after the third frame.
REQ-038 Serializer held busy for 10 cycles in START.
- o_tx_start stays low and rises in the first cycle busy=0; exactly one start.
REQ-039 enable dropped during the first of two frames.
- Frame 1 completes, FSM goes to IDLE with no IRQ, second byte not popped.
- Re-enable sends it.
REQ-040 Reset asserted in WAIT_DONE.
- All outputs 0 immediately; a stray i_tx_done afterward leaves sent_count=0.
REQ-041 Preload sent_count=16'hFFFF (force) and send 1 frame -> count reads 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default sizes for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned DefaultDataSize = 8;
  localparam int unsigned DefaultGapWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StStart,
    StWaitDone,
    StGap
  } sched_state_e;

endpackage

// File: rtl/uart_tx_sched.sv
// Pulls bytes from the TX FIFO and hands them to the serializer one frame at a time,
// with an optional programmable idle gap between frames.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefaultDataSize,
  parameter int unsigned GAP_WIDTH = DefaultGapWidth
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [GAP_WIDTH-1:0] i_gap_cycles,
  input  logic                 i_fifo_empty,
  input  logic [DATA_SIZE-1:0] i_fifo_data,
  output logic                 o_fifo_read_en,
  input  logic                 i_tx_busy,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [DATA_SIZE-1:0] o_tx_data,
  output logic                 o_active,
  output logic                 o_irq_done,
  output logic [15:0]          o_sent_count
);

  sched_state_e         r_state;
  sched_state_e         w_state_next;
  logic [GAP_WIDTH-1:0] r_gap_cnt;
  logic [GAP_WIDTH-1:0] w_gap_cnt_next;
  logic [DATA_SIZE-1:0] r_tx_data;
  logic [DATA_SIZE-1:0] w_tx_data_next;
  logic [15:0]          r_sent_count;
  logic [15:0]          w_sent_count_next;
  logic                 r_irq_done;
  logic                 w_irq_done_next;
  logic                 w_decide;
  logic                 w_can_pop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // w_decide marks the end of a frame (plus gap): pick the next frame or go idle.
  always_comb begin
    w_can_pop    = i_enable & ~i_fifo_empty;
    w_decide     = 1'b0;
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_can_pop) w_state_next = StPop;
      end
      StPop: begin
        w_state_next = StStart;
      end
      StStart: begin
        if (!i_tx_busy) w_state_next = StWaitDone;
      end
      StWaitDone: begin
        if (i_tx_done) begin
          if (i_gap_cycles == '0) begin
            w_decide = 1'b1;
          end else begin
            w_state_next = StGap;
          end
        end
      end
      StGap: begin
        if (r_gap_cnt == '0) w_decide = 1'b1;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
    if (w_decide) begin
      w_state_next = w_can_pop ? StPop : StIdle;
    end
  end

  always_comb begin
    w_tx_data_next    = r_tx_data;
    w_sent_count_next = r_sent_count;
    w_gap_cnt_next    = r_gap_cnt;
    w_irq_done_next   = w_decide & i_fifo_empty;
    if (r_state == StPop) begin
      w_tx_data_next = i_fifo_data;
    end
    if ((r_state == StWaitDone) && i_tx_done) begin
      w_sent_count_next = r_sent_count + 16'd1;
      if (i_gap_cycles != '0) begin
        w_gap_cnt_next = i_gap_cycles - GAP_WIDTH'(1);
      end
    end
    if ((r_state == StGap) && (r_gap_cnt != '0)) begin
      w_gap_cnt_next = r_gap_cnt - GAP_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_data    <= '0;
      r_sent_count <= '0;
      r_gap_cnt    <= '0;
      r_irq_done   <= 1'b0;
    end else begin
      r_tx_data    <= w_tx_data_next;
      r_sent_count <= w_sent_count_next;
      r_gap_cnt    <= w_gap_cnt_next;
      r_irq_done   <= w_irq_done_next;
    end
  end

  // Start strobe is the only output that looks at a live input (serializer busy).
  always_comb begin
    o_fifo_read_en = (r_state == StPop);
    o_tx_start     = (r_state == StStart) & ~i_tx_busy;
    o_active       = (r_state != StIdle);
    o_irq_done     = r_irq_done;
    o_tx_data      = r_tx_data;
    o_sent_count   = r_sent_count;
  end

endmodule
